// File: rtl/grayscale_controller.sv
// Frame sequencer for a handshaked grayscale converter: accepts RGB pixels upstream,
// pulses the converter, waits (with timeout) for its result and forwards it downstream.
module grayscale_controller #(
    parameter int P_PIXEL_DEPTH = 24,
    parameter int P_WIDTH       = 640,
    parameter int P_HEIGHT      = 480,
    parameter int P_TIMEOUT     = 15
) (
    input  logic                         I_CLK,
    input  logic                         I_RESET,
    input  logic                         I_START,
    input  logic                         I_PIXEL_VALID,
    input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
    output logic                         O_PIXEL_READY,
    output logic                         O_GS_ENABLE,
    output logic [P_PIXEL_DEPTH-1:0]     O_GS_PIXEL,
    input  logic [P_PIXEL_DEPTH-1:0]     I_GS_PIXEL,
    input  logic                         I_GS_DONE,
    output logic                         O_PIXEL_VALID,
    output logic [P_PIXEL_DEPTH-1:0]     O_PIXEL,
    input  logic                         I_PIXEL_READY,
    output logic [$clog2(P_WIDTH)-1:0]   O_COL,
    output logic [$clog2(P_HEIGHT)-1:0]  O_ROW,
    output logic                         O_BUSY,
    output logic                         O_FRAME_DONE,
    output logic                         O_ERROR
);

    localparam int CW = $clog2(P_WIDTH);
    localparam int RW = $clog2(P_HEIGHT);
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(P_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(P_HEIGHT - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(P_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACCEPT    = 3'd1,
        S_CONVERT   = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_EMIT      = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t                   state_r, state_s;
    logic [P_PIXEL_DEPTH-1:0] gs_pixel_r, gs_pixel_s;
    logic [P_PIXEL_DEPTH-1:0] pixel_r, pixel_s;
    logic [CW-1:0]            col_r, col_s;
    logic [RW-1:0]            row_r, row_s;
    logic [TW-1:0]            timer_r, timer_s;
    logic                     error_r, error_s;
    logic                     ready_r, enable_r, valid_r, busy_r, frame_done_r;

    // Next-state, counter and datapath-register logic.
    always_comb begin
        state_s    = state_r;
        gs_pixel_s = gs_pixel_r;
        pixel_s    = pixel_r;
        col_s      = col_r;
        row_s      = row_r;
        timer_s    = timer_r;
        error_s    = error_r;
        case (state_r)
            S_IDLE: begin
                if (I_START) begin
                    state_s = S_ACCEPT;
                    col_s   = {CW{1'b0}};
                    row_s   = {RW{1'b0}};
                    error_s = 1'b0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (I_PIXEL_VALID) begin
                    gs_pixel_s = I_PIXEL;
                    state_s    = S_CONVERT;
                end else begin
                    state_s = S_ACCEPT;
                end
            end
            S_CONVERT: begin
                timer_s = {TW{1'b0}};
                state_s = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // DONE wins over an expiring timer on the same cycle.
                if (I_GS_DONE) begin
                    pixel_s = I_GS_PIXEL;
                    state_s = S_EMIT;
                end else if (timer_r == TIMER_LAST) begin
                    error_s = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            S_EMIT: begin
                if (I_PIXEL_READY) begin
                    if ((row_r == ROW_LAST) && (col_r == COL_LAST)) begin
                        state_s = S_FINISH;
                    end else if (col_r == COL_LAST) begin
                        col_s   = {CW{1'b0}};
                        row_s   = row_r + RW'(1);
                        state_s = S_ACCEPT;
                    end else begin
                        col_s   = col_r + CW'(1);
                        state_s = S_ACCEPT;
                    end
                end else begin
                    state_s = S_EMIT;
                end
            end
            S_FINISH: begin
                col_s   = {CW{1'b0}};
                row_s   = {RW{1'b0}};
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers; strobes are decoded from the next state so they
    // are registered yet aligned with the state they belong to.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_r      <= S_IDLE;
            gs_pixel_r   <= {P_PIXEL_DEPTH{1'b0}};
            pixel_r      <= {P_PIXEL_DEPTH{1'b0}};
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            timer_r      <= {TW{1'b0}};
            error_r      <= 1'b0;
            ready_r      <= 1'b0;
            enable_r     <= 1'b0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            gs_pixel_r   <= gs_pixel_s;
            pixel_r      <= pixel_s;
            col_r        <= col_s;
            row_r        <= row_s;
            timer_r      <= timer_s;
            error_r      <= error_s;
            ready_r      <= (state_s == S_ACCEPT);
            enable_r     <= (state_s == S_CONVERT);
            valid_r      <= (state_s == S_EMIT);
            busy_r       <= (state_s != S_IDLE);
            frame_done_r <= (state_s == S_FINISH);
        end
    end

    assign O_PIXEL_READY = ready_r;
    assign O_GS_ENABLE   = enable_r;
    assign O_GS_PIXEL    = gs_pixel_r;
    assign O_PIXEL_VALID = valid_r;
    assign O_PIXEL       = pixel_r;
    assign O_COL         = col_r;
    assign O_ROW         = row_r;
    assign O_BUSY        = busy_r;
    assign O_FRAME_DONE  = frame_done_r;
    assign O_ERROR       = error_r;

endmodule

// File: tb/tb_grayscale_controller.sv
// Directed bench for grayscale_controller on a 2x2 frame: table-driven pixel
// transactions plus hand-written timeout, exact-timeout and mid-frame reset sequences.
module tb_grayscale_controller;

    localparam int PD = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [PD-1:0] in_pixel;
    logic          in_ready_o;
    logic          gs_en;
    logic [PD-1:0] gs_pix_o;
    logic [PD-1:0] gs_res;
    logic          gs_done;
    logic          out_valid;
    logic [PD-1:0] out_pixel;
    logic          out_ready;
    logic [0:0]    col;
    logic [0:0]    row;
    logic          busy;
    logic          frame_done;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [PD-1:0] pix;
        logic [PD-1:0] gs;
        int            dly;
        int            stall;
        int            exp_col;
        int            exp_row;
    } vec_t;

    vec_t vecs [8];

    grayscale_controller #(
        .P_PIXEL_DEPTH(PD), .P_WIDTH(2), .P_HEIGHT(2), .P_TIMEOUT(15)
    ) dut (
        .I_CLK(clk), .I_RESET(rst), .I_START(start),
        .I_PIXEL_VALID(in_valid), .I_PIXEL(in_pixel), .O_PIXEL_READY(in_ready_o),
        .O_GS_ENABLE(gs_en), .O_GS_PIXEL(gs_pix_o), .I_GS_PIXEL(gs_res), .I_GS_DONE(gs_done),
        .O_PIXEL_VALID(out_valid), .O_PIXEL(out_pixel), .I_PIXEL_READY(out_ready),
        .O_COL(col), .O_ROW(row), .O_BUSY(busy), .O_FRAME_DONE(frame_done), .O_ERROR(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " ready"}, 32'(in_ready_o), 32'd0);
        chk({tag, " enable"}, 32'(gs_en), 32'd0);
        chk({tag, " gs_pixel"}, 32'(gs_pix_o), 32'd0);
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
        chk({tag, " pixel"}, 32'(out_pixel), 32'd0);
        chk({tag, " col"}, 32'(col), 32'd0);
        chk({tag, " row"}, 32'(row), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start busy", 32'(busy), 32'd1);
        chk("start ready", 32'(in_ready_o), 32'd1);
        chk("start col", 32'(col), 32'd0);
        chk("start row", 32'(row), 32'd0);
        chk("start error", 32'(error), 32'd0);
    endtask

    // Waits (bounded) for ready, hands over one pixel and leaves the converter enabled.
    task automatic issue_pixel(input logic [PD-1:0] pix);
        int n = 0;
        while (!in_ready_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready wait", 32'(in_ready_o), 32'd1);
        in_valid = 1'b1;
        in_pixel = pix;
        @(negedge clk);
        in_valid = 1'b0;
        chk("enable pulse", 32'(gs_en), 32'd1);
        chk("gs_pixel", 32'(gs_pix_o), 32'(pix));
        chk("ready in convert", 32'(in_ready_o), 32'd0);
    endtask

    // Converter model: DONE presented dly cycles after the enable cycle.
    task automatic convert(input logic [PD-1:0] gs, input int dly);
        for (int k = 1; k <= dly; k++) begin
            @(negedge clk);
            chk("enable dropped", 32'(gs_en), 32'd0);
            chk("no valid while converting", 32'(out_valid), 32'd0);
            if (k == dly) begin
                gs_done = 1'b1;
                gs_res  = gs;
            end
        end
        @(negedge clk);
        gs_done = 1'b0;
        gs_res  = 24'h0;
    endtask

    task automatic do_pixel(input vec_t v);
        issue_pixel(v.pix);
        if (v.stall > 0) out_ready = 1'b0;
        convert(v.gs, v.dly);
        chk("valid after done", 32'(out_valid), 32'd1);
        chk("out pixel", 32'(out_pixel), 32'(v.gs));
        chk("col", 32'(col), 32'(v.exp_col));
        chk("row", 32'(row), 32'(v.exp_row));
        chk("no error", 32'(error), 32'd0);
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk("stall valid", 32'(out_valid), 32'd1);
            chk("stall pixel", 32'(out_pixel), 32'(v.gs));
            chk("stall ready", 32'(in_ready_o), 32'd0);
            chk("stall col", 32'(col), 32'(v.exp_col));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("valid after handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{24'h102030, 24'h0A0A0A, 1, 0, 0, 0};
        vecs[1] = '{24'h405060, 24'h1B1B1B, 1, 0, 1, 0};
        vecs[2] = '{24'h708090, 24'h2C2C2C, 1, 0, 0, 1};
        vecs[3] = '{24'hA0B0C0, 24'h3D3D3D, 1, 0, 1, 1};
        vecs[4] = '{24'hFF8040, 24'h6F6F6F, 3, 0, 0, 0};
        vecs[5] = '{24'h123456, 24'h777777, 2, 4, 1, 0};
        vecs[6] = '{24'h00FF00, 24'h969696, 1, 0, 0, 1};
        vecs[7] = '{24'hFFFFFF, 24'hFFFFFF, 4, 0, 1, 1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = 24'h0;
        gs_res = 24'h0; gs_done = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        // Two full 2x2 frames from the table.
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) start_frame();
            do_pixel(vecs[i]);
            if (i % 4 == 3) begin
                chk("frame_done pulse", 32'(frame_done), 32'd1);
                chk("busy in finish", 32'(busy), 32'd1);
                @(negedge clk);
                chk("frame_done single", 32'(frame_done), 32'd0);
                chk("busy after frame", 32'(busy), 32'd0);
                chk("col cleared", 32'(col), 32'd0);
                chk("row cleared", 32'(row), 32'd0);
            end
        end

        // Converter never answers: error 15 cycles into WAIT_DONE.
        start_frame();
        issue_pixel(24'hABCDEF);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            chk("no error before timeout", 32'(error), 32'd0);
            chk("busy while waiting", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("timeout error", 32'(error), 32'd1);
        chk("timeout idle", 32'(busy), 32'd0);
        chk("timeout no frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        chk("error sticky", 32'(error), 32'd1);
        chk("no frame_done later", 32'(frame_done), 32'd0);

        // Restart clears the error; DONE on the exact expiry cycle still succeeds.
        start_frame();
        do_pixel('{24'h010203, 24'h424242, 15, 0, 0, 0});
        chk("exact timeout error clear", 32'(error), 32'd0);
        chk("exact timeout busy", 32'(busy), 32'd1);

        // Reset while the second pixel sits in EMIT.
        issue_pixel(24'h0A0B0C);
        out_ready = 1'b0;
        convert(24'h555555, 1);
        chk("emit before reset", 32'(out_valid), 32'd1);
        chk("col before reset", 32'(col), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        all_zero("midframe reset");
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("reset no frame_done", 32'(frame_done), 32'd0);
        start_frame();
        do_pixel('{24'h0C0B0A, 24'h161616, 2, 0, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
